// File: rtl/ram_playback.sv
// Plays back digits stored in a small RAM onto a seven-segment display, one entry at a time.
// Latency: one read strobe, then one cycle of RAM latency, then HOLD_TICKS ticks shown and GAP_TICKS ticks blanked per entry.
// Backpressure: none; start_i is ignored while busy, and stop_i (or reset) aborts at once without a done pulse.
module ram_playback #(
  parameter int DEPTH      = 8,
  parameter int HOLD_TICKS = 3,   // must be >= 1
  parameter int GAP_TICKS  = 1    // must be >= 1
) (
  input  logic       clk_i,
  input  logic       reset_n,
  input  logic       tick_i,
  input  logic       start_i,
  input  logic       stop_i,
  input  logic       loop_i,
  input  logic [3:0] count_i,
  output logic       rd_en_o,
  output logic [2:0] rd_adr_o,
  input  logic [4:0] rd_data_i,
  output logic [3:0] digit_o,
  output logic       blank_o,
  output logic       busy_o,
  output logic       done_o,
  output logic       bad_o
);

  localparam int TW = 8;
  localparam logic [3:0]    DEPTH_C   = 4'(DEPTH);
  localparam logic [TW-1:0] HOLD_LAST = TW'(HOLD_TICKS - 1);
  localparam logic [TW-1:0] GAP_LAST  = TW'(GAP_TICKS - 1);

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    WAIT,
    SHOW,
    GAP,
    DONE
  } state_t;

  state_t        state;
  logic [2:0]    adr;
  logic [3:0]    count_q;
  logic [TW-1:0] tick_cnt;
  logic          last_entry;

  // The read address register doubles as the playback position.
  assign rd_adr_o   = adr;
  assign last_entry = ({1'b0, adr} == (count_q - 4'd1));

  // Playback sequencer; every output is registered and updated on the transition that enters its state.
  always_ff @(posedge clk_i or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      adr      <= '0;
      count_q  <= '0;
      tick_cnt <= '0;
      digit_o  <= '0;
      blank_o  <= 1'b1;
      busy_o   <= 1'b0;
      done_o   <= 1'b0;
      rd_en_o  <= 1'b0;
      bad_o    <= 1'b0;
    end else if (state != IDLE && stop_i) begin
      // Abort takes priority over ticks and starts; no done pulse on abort.
      state    <= IDLE;
      tick_cnt <= '0;
      blank_o  <= 1'b1;
      busy_o   <= 1'b0;
      done_o   <= 1'b0;
      rd_en_o  <= 1'b0;
    end else begin
      rd_en_o <= 1'b0;
      done_o  <= 1'b0;
      case (state)
        IDLE: begin
          if (start_i && !stop_i) begin
            count_q  <= (count_i > DEPTH_C) ? DEPTH_C : count_i;
            adr      <= '0;
            bad_o    <= 1'b0;
            tick_cnt <= '0;
            if (count_i == 4'd0) begin
              state  <= DONE;
              done_o <= 1'b1;
            end else begin
              state   <= FETCH;
              rd_en_o <= 1'b1;
              busy_o  <= 1'b1;
            end
          end
        end
        FETCH: begin
          state <= WAIT;
        end
        WAIT: begin
          // RAM data arrives one cycle after the strobe; the digit is captured even for
          // invalid entries, but the display stays blank for them.
          digit_o  <= rd_data_i[3:0];
          blank_o  <= ~rd_data_i[4];
          if (!rd_data_i[4]) begin
            bad_o <= 1'b1;
          end
          tick_cnt <= '0;
          state    <= SHOW;
        end
        SHOW: begin
          if (tick_i) begin
            if (tick_cnt == HOLD_LAST) begin
              tick_cnt <= '0;
              blank_o  <= 1'b1;
              state    <= GAP;
            end else begin
              tick_cnt <= tick_cnt + 8'd1;
            end
          end
        end
        GAP: begin
          if (tick_i) begin
            if (tick_cnt == GAP_LAST) begin
              tick_cnt <= '0;
              if (last_entry && !loop_i) begin
                state  <= DONE;
                done_o <= 1'b1;
                busy_o <= 1'b0;
              end else begin
                adr     <= last_entry ? 3'd0 : adr + 3'd1;
                state   <= FETCH;
                rd_en_o <= 1'b1;
              end
            end else begin
              tick_cnt <= tick_cnt + 8'd1;
            end
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/ram_playback.md
RAM_PLAYBACK -- requirements
Module: ram_playback

Interface
REQ-001 Parameter DEPTH, default 8: number of RAM entries; address width is 3 bits.
REQ-002 Parameter HOLD_TICKS, default 3: number of tick_i pulses each digit is shown.
REQ-003 Parameter GAP_TICKS, default 1: number of tick_i pulses the display is blanked between digits.
REQ-004 Port clk_i, input, 1 bit: the block's single clock; all logic is on its rising edge.
REQ-005 Port reset_n, input, 1 bit: reset, asynchronous assert, active-low.
REQ-006 Port tick_i, input, 1 bit: one-cycle timing strobe from the slow-clock divider.
REQ-007 Port start_i, input, 1 bit: single-cycle request to begin playback.
REQ-008 Port stop_i, input, 1 bit: abort playback.
REQ-009 Port loop_i, input, 1 bit: when high, playback repeats from address 0 after the last entry.
REQ-010 Port count_i, input, 4 bits: number of stored entries, 0..DEPTH.
REQ-011 Port rd_en_o, output, 1 bit: RAM read strobe.
REQ-012 Port rd_adr_o, output, 3 bits: RAM read address.
REQ-013 Port rd_data_i, input, 5 bits: RAM read data; bit 4 is the entry-valid flag and bits 3:0 are the digit.
REQ-014 Port digit_o, output, 4 bits: digit to the seven-segment decoder.
REQ-015 Port blank_o, output, 1 bit: 1 means the display is off.
REQ-016 Port busy_o, output, 1 bit: 1 while playback is active.
REQ-017 Port done_o, output, 1 bit: one-cycle pulse when a non-looping playback completes.
REQ-018 Port bad_o, output, 1 bit: sticky flag, set when an invalid entry is read.

Function
REQ-019 The FSM SHALL have the states IDLE, FETCH, WAIT, SHOW, GAP and DONE.
REQ-020 IDLE: on start_i with stop_i low:
- latch count_i into count_q, saturating values above DEPTH to DEPTH;
- clear the address to 0 and clear bad_o;
- go to FETCH, or to DONE if the latched count is 0.
REQ-021 FETCH: assert rd_en_o for exactly one cycle with rd_adr_o = current address, then go to WAIT.
REQ-022 RAM read latency is 1 cycle. WAIT SHALL capture rd_data_i on the cycle after FETCH, then go to SHOW.
REQ-023 SHOW, valid entry (bit 4 = 1): digit_o = captured bits 3:0 and blank_o = 0.
REQ-024 SHOW, invalid entry (bit 4 = 0): blank_o = 1 and bad_o set.
REQ-025 SHOW SHALL last until HOLD_TICKS tick_i pulses have been counted, then go to GAP.
- Ticks are counted only while in SHOW; a tick in the same cycle as entering SHOW is not counted.
REQ-026 GAP: blank_o = 1 for GAP_TICKS ticks. Then:
- if address = count_q-1 and loop_i = 0: go to DONE;
- if address = count_q-1 and loop_i = 1: address wraps to 0, go to FETCH;
- otherwise: address increments, go to FETCH.
REQ-027 loop_i SHALL be sampled only at the GAP exit decision.
REQ-028 DONE: assert done_o for one cycle, then go to IDLE.
REQ-029 stop_i in any non-IDLE state SHALL force IDLE on the next edge, with no done_o pulse.
- stop_i wins over a simultaneous start_i or tick_i.
REQ-030 start_i while busy SHALL be ignored.
REQ-031 busy_o = 1 in FETCH, WAIT, SHOW and GAP; 0 in IDLE and DONE.
REQ-032 Outside SHOW, blank_o SHALL be 1. digit_o holds the last captured value.
REQ-033 rd_en_o SHALL be 0 in every state except FETCH.

Reset
REQ-034 While reset_n = 0: state = IDLE, address = 0, count_q = 0, tick counter = 0, digit_o = 0, blank_o = 1, busy_o = 0, done_o = 0, rd_en_o = 0, bad_o = 0.
REQ-035 Reset asserted mid-playback SHALL take effect immediately. No done_o is produced, and the block waits in IDLE for a new start_i.

Verification
REQ-036 count_i=3, RAM={0x11,0x12,0x13}, loop_i=0 -> digits 1,2,3 each shown 3 ticks with 1-tick blank gaps; one done_o pulse; busy_o falls.
REQ-037 count_i=0, start_i -> done_o pulses within 2 cycles; rd_en_o never asserted; blank_o stays 1.
REQ-038 count_i=2, loop_i=1, RAM={0x15,0x17} -> sequence 5,7,5,7... with rd_adr_o wrapping 1->0; no done_o; stop_i -> IDLE next edge, blank_o=1.
REQ-039 count_i=12 -> saturates to 8; addresses 0..7 read once each; done_o after the 8th gap.
REQ-040 RAM entry 1 = 0x04 (invalid) among valid entries -> blank for that hold period; bad_o=1 and remains set until the next start_i.
REQ-041 reset_n pulsed low during SHOW, and start_i+stop_i asserted together in IDLE -> all outputs at reset values, state IDLE, no done_o.
